// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder and its initiator-side peers.
// Holds the handshake state encoding, the latency bounds and the latency
// counter preload helper. Both sides import this so they agree on encoding.
package mem_if_pkg;

   localparam int LAT_MIN      = 1;
   localparam int LAT_MAX      = 15;
   localparam int LAT_CNT_WID  = 4;
   localparam int BEAT_CNT_WID = 32;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RD_LATENCY = 3'd1,
      ST_RD_PULSE   = 3'd2,
      ST_RD_HOLD    = 3'd3,
      ST_WR_LATENCY = 3'd4,
      ST_WR_PULSE   = 3'd5,
      ST_WR_HOLD    = 3'd6
   } mem_state_t;

   // Counter preload for a latency of lat cycles; out-of-range values are
   // clamped into [LAT_MIN, LAT_MAX] so the counter can never wrap.
   function automatic logic [LAT_CNT_WID-1:0] lat_preload(input int lat);
      int clamped;
      clamped = lat;
      if (clamped < LAT_MIN) clamped = LAT_MIN;
      if (clamped > LAT_MAX) clamped = LAT_MAX;
      return LAT_CNT_WID'(clamped - 1);
   endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Local word store for mem_responder.
// One write port, one synchronous read port. The array itself has no reset
// so its contents survive reset; only the read output register is cleared.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset (read register only)
//   we     - write strobe; wdata stored at waddr on the rising edge
//   waddr  - write word index
//   wdata  - write data
//   re     - read strobe; mem[raddr] captured into rdata on the rising edge
//   raddr  - read word index
//   rdata  - registered read data, held until the next read
module mem_responder_ram #(
   parameter int ADDR_WID = 14,
   parameter int DATA_WID = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [ADDR_WID-1:0] waddr,
   input  logic [DATA_WID-1:0] wdata,
   input  logic                re,
   input  logic [ADDR_WID-1:0] raddr,
   output logic [DATA_WID-1:0] rdata
);

   logic [DATA_WID-1:0] mem [0:(1<<ADDR_WID)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: serves read and write beats from a local word store
// with fixed, parameterised latency and a one-cycle ready pulse per beat.
// Ports:
//   clk, reset                 - clock (rising edge), async active-high reset
//   read_enable, write_enable  - initiator request levels (read wins ties)
//   finish_read, finish_write  - "next beat" pulses, honoured in HOLD states
//   read_addr, write_addr      - byte addresses, word index = addr[ADDR_WID+1:2]
//   write_data                 - write payload, sampled on accept
//   load_en/addr/data          - backdoor preload, honoured only in IDLE
//   read_data                  - read payload, valid while read_ready==1
//   read_ready, write_ready    - one-cycle beat completion pulses (0 or 1)
//   rd_beats, wr_beats         - completed beat counters (wrap at 2^32)
//   busy                       - state != IDLE
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | no beat in flight; preload or accept a request
// ST_RD_LATENCY | read accepted, counting down read latency
// ST_RD_PULSE   | read_ready high, read_data valid
// ST_RD_HOLD    | waiting for finish_read (next beat) or read_enable low
// ST_WR_LATENCY | write accepted, counting down write latency
// ST_WR_PULSE   | write_ready high, word committed at end of cycle
// ST_WR_HOLD    | waiting for finish_write (next beat) or write_enable low
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_WID = 14,
   parameter int DATA_WID = 32,
   parameter int RD_LAT   = 2,
   parameter int WR_LAT   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                read_enable,
   input  logic                write_enable,
   input  logic                finish_read,
   input  logic                finish_write,
   input  logic [63:0]         read_addr,
   input  logic [63:0]         write_addr,
   input  logic [DATA_WID-1:0] write_data,
   input  logic                load_en,
   input  logic [ADDR_WID-1:0] load_addr,
   input  logic [DATA_WID-1:0] load_data,
   output logic [DATA_WID-1:0] read_data,
   output logic [63:0]         read_ready,
   output logic [63:0]         write_ready,
   output logic [31:0]         rd_beats,
   output logic [31:0]         wr_beats,
   output logic                busy
);

   localparam logic [LAT_CNT_WID-1:0] RD_PRELOAD = lat_preload(RD_LAT);
   localparam logic [LAT_CNT_WID-1:0] WR_PRELOAD = lat_preload(WR_LAT);

   mem_state_t state_q, state_d;
   logic [LAT_CNT_WID-1:0] cnt_q, cnt_d;
   logic [ADDR_WID-1:0]    rd_idx_q, rd_idx_d;
   logic [ADDR_WID-1:0]    wr_idx_q, wr_idx_d;
   logic [DATA_WID-1:0]    wr_data_q, wr_data_d;
   logic [BEAT_CNT_WID-1:0] rd_beats_q, wr_beats_q;

   logic                ram_we;
   logic [ADDR_WID-1:0] ram_waddr;
   logic [DATA_WID-1:0] ram_wdata;
   logic                ram_re;

   // Slicing the byte address drops the upper bits, which gives the
   // modulo-2^ADDR_WID wrap of the word index for free.
   logic [ADDR_WID-1:0] rd_word, wr_word;
   assign rd_word = read_addr[ADDR_WID+1:2];
   assign wr_word = write_addr[ADDR_WID+1:2];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{read_addr[63:ADDR_WID+2], read_addr[1:0],
                               write_addr[63:ADDR_WID+2], write_addr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rd_idx_q   <= '0;
         wr_idx_q   <= '0;
         wr_data_q  <= '0;
         rd_beats_q <= '0;
         wr_beats_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_idx_q  <= rd_idx_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
         if (state_q == ST_RD_PULSE) rd_beats_q <= rd_beats_q + 32'd1;
         if (state_q == ST_WR_PULSE) wr_beats_q <= wr_beats_q + 32'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_idx_d  = rd_idx_q;
      wr_idx_d  = wr_idx_q;
      wr_data_d = wr_data_q;
      ram_we    = 1'b0;
      ram_waddr = wr_idx_q;
      ram_wdata = wr_data_q;
      ram_re    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load_en) begin
               ram_we    = 1'b1;
               ram_waddr = load_addr;
               ram_wdata = load_data;
            end else if (read_enable) begin
               state_d  = ST_RD_LATENCY;
               cnt_d    = RD_PRELOAD;
               rd_idx_d = rd_word;
            end else if (write_enable) begin
               state_d   = ST_WR_LATENCY;
               cnt_d     = WR_PRELOAD;
               wr_idx_d  = wr_word;
               wr_data_d = write_data;
            end
         end

         ST_RD_LATENCY: begin
            if (!read_enable) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               // Capture into the RAM output register on this edge so the
               // word is present for the whole RD_PULSE cycle.
               state_d = ST_RD_PULSE;
               ram_re  = 1'b1;
            end else begin
               cnt_d = cnt_q - LAT_CNT_WID'(1);
            end
         end

         ST_RD_PULSE: state_d = ST_RD_HOLD;

         ST_RD_HOLD: begin
            if (finish_read) begin
               state_d  = ST_RD_LATENCY;
               cnt_d    = RD_PRELOAD;
               rd_idx_d = rd_word;
            end else if (!read_enable) begin
               state_d = ST_IDLE;
            end
         end

         ST_WR_LATENCY: begin
            if (!write_enable) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_WR_PULSE;
            end else begin
               cnt_d = cnt_q - LAT_CNT_WID'(1);
            end
         end

         ST_WR_PULSE: begin
            ram_we  = 1'b1;
            state_d = ST_WR_HOLD;
         end

         ST_WR_HOLD: begin
            if (finish_write) begin
               state_d   = ST_WR_LATENCY;
               cnt_d     = WR_PRELOAD;
               wr_idx_d  = wr_word;
               wr_data_d = write_data;
            end else if (!write_enable) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   mem_responder_ram #(
      .ADDR_WID (ADDR_WID),
      .DATA_WID (DATA_WID)
   ) u_ram (
      .clk   (clk),
      .rst   (reset),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (rd_idx_q),
      .rdata (read_data)
   );

   // Decoded straight from the async-reset state register so reset clears
   // the pulses immediately, without waiting for a clock edge.
   assign read_ready  = {63'd0, state_q == ST_RD_PULSE};
   assign write_ready = {63'd0, state_q == ST_WR_PULSE};
   assign rd_beats    = rd_beats_q;
   assign wr_beats    = wr_beats_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int ADDR_WID = 14;
   localparam int DATA_WID = 32;
   localparam int RD_LAT   = 2;
   localparam int WR_LAT   = 1;

   logic                clk = 1'b0;
   logic                reset;
   logic                read_enable, write_enable;
   logic                finish_read, finish_write;
   logic [63:0]         read_addr, write_addr;
   logic [DATA_WID-1:0] write_data;
   logic                load_en;
   logic [ADDR_WID-1:0] load_addr;
   logic [DATA_WID-1:0] load_data;
   logic [DATA_WID-1:0] read_data;
   logic [63:0]         read_ready, write_ready;
   logic [31:0]         rd_beats, wr_beats;
   logic                busy;

   int tests  = 0;
   int failed = 0;
   int exp_rd = 0;
   int exp_wr = 0;

   always #5 clk = ~clk;

   mem_responder #(
      .ADDR_WID (ADDR_WID),
      .DATA_WID (DATA_WID),
      .RD_LAT   (RD_LAT),
      .WR_LAT   (WR_LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .read_enable  (read_enable),
      .write_enable (write_enable),
      .finish_read  (finish_read),
      .finish_write (finish_write),
      .read_addr    (read_addr),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .read_data    (read_data),
      .read_ready   (read_ready),
      .write_ready  (write_ready),
      .rd_beats     (rd_beats),
      .wr_beats     (wr_beats),
      .busy         (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int idx, input logic [DATA_WID-1:0] d);
      load_en   = 1'b1;
      load_addr = ADDR_WID'(idx);
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      read_enable = 0; write_enable = 0; finish_read = 0; finish_write = 0;
      read_addr = '0; write_addr = '0; write_data = '0;
      load_en = 0; load_addr = '0; load_data = '0;
      tick();
      tick();
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %0b want 0", busy); end
      tests++; if (read_ready !== 64'd0) begin failed++; $display("FAIL reset_read_ready got %0d want 0", read_ready); end
      tests++; if (write_ready !== 64'd0) begin failed++; $display("FAIL reset_write_ready got %0d want 0", write_ready); end
      tests++; if (read_data !== 32'd0) begin failed++; $display("FAIL reset_read_data got %0h want 0", read_data); end
      tests++; if (rd_beats !== 32'd0 || wr_beats !== 32'd0) begin failed++; $display("FAIL reset_beats got %0d/%0d want 0/0", rd_beats, wr_beats); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_preload_read();
      for (int i = 0; i < 4; i++) preload(i, DATA_WID'(10 + i));
      read_addr   = 64'd0;
      read_enable = 1'b1;
      tick();
      for (int b = 0; b < 4; b++) begin
         int lat;
         bit seen;
         lat = 0; seen = 0;
         for (int c = 1; c <= 20 && !seen; c++) begin
            if (read_ready === 64'd1) begin seen = 1; lat = c; end
            else tick();
         end
         tests++; if (lat != RD_LAT + 1) begin failed++; $display("FAIL read_latency beat %0d got %0d want %0d", b, lat, RD_LAT + 1); end
         tests++; if (read_data !== DATA_WID'(10 + b)) begin failed++; $display("FAIL read_data beat %0d got %0d want %0d", b, read_data, 10 + b); end
         tick();
         exp_rd++;
         tests++; if (read_ready !== 64'd0) begin failed++; $display("FAIL read_ready_one_cycle beat %0d got %0d want 0", b, read_ready); end
         tests++; if (rd_beats !== 32'(exp_rd)) begin failed++; $display("FAIL rd_beats beat %0d got %0d want %0d", b, rd_beats, exp_rd); end
         if (b < 3) begin
            read_addr   = read_addr + 64'd4;
            finish_read = 1'b1;
            tick();
            finish_read = 1'b0;
         end
      end
      read_enable = 1'b0;
      tick();
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL read_return_idle busy got %0b want 0", busy); end
   endtask

   task automatic test_write_burst();
      int pulses;
      pulses = 0;
      write_addr   = 64'h100;
      write_data   = 32'hA0;
      write_enable = 1'b1;
      tick();
      for (int b = 0; b < 4; b++) begin
         int lat;
         bit seen;
         lat = 0; seen = 0;
         write_data = 32'hFFFF_FFFF;
         for (int c = 1; c <= 20 && !seen; c++) begin
            if (write_ready === 64'd1) begin seen = 1; lat = c; pulses++; end
            else tick();
         end
         tests++; if (lat != WR_LAT + 1) begin failed++; $display("FAIL write_latency beat %0d got %0d want %0d", b, lat, WR_LAT + 1); end
         tick();
         if (write_ready === 64'd1) pulses++;
         if (b < 3) begin
            write_addr   = write_addr + 64'd4;
            write_data   = DATA_WID'(32'hA1 + b);
            finish_write = 1'b1;
            tick();
            finish_write = 1'b0;
         end
      end
      exp_wr += 4;
      tests++; if (pulses != 4) begin failed++; $display("FAIL write_ready_count got %0d want 4", pulses); end
      tests++; if (wr_beats !== 32'(exp_wr)) begin failed++; $display("FAIL wr_beats got %0d want %0d", wr_beats, exp_wr); end
      write_enable = 1'b0;
      tick();
      read_addr   = 64'h100;
      read_enable = 1'b1;
      tick();
      for (int b = 0; b < 4; b++) begin
         bit seen;
         seen = 0;
         for (int c = 1; c <= 20 && !seen; c++) begin
            if (read_ready === 64'd1) seen = 1;
            else tick();
         end
         tests++; if (!seen || read_data !== DATA_WID'(32'hA0 + b)) begin failed++; $display("FAIL write_readback beat %0d got %0h want %0h", b, read_data, 32'hA0 + b); end
         tick();
         exp_rd++;
         if (b < 3) begin
            read_addr   = read_addr + 64'd4;
            finish_read = 1'b1;
            tick();
            finish_read = 1'b0;
         end
      end
      read_enable = 1'b0;
      tick();
   endtask

   task automatic test_both_requests();
      int rd_pulses, wr_pulses;
      bit seen;
      rd_pulses = 0; wr_pulses = 0; seen = 0;
      read_addr    = 64'h8;
      write_addr   = 64'h200;
      write_data   = 32'h55;
      read_enable  = 1'b1;
      write_enable = 1'b1;
      tick();
      for (int c = 0; c < 8; c++) begin
         if (read_ready === 64'd1) rd_pulses++;
         if (write_ready === 64'd1) wr_pulses++;
         tick();
      end
      exp_rd++;
      tests++; if (rd_pulses != 1) begin failed++; $display("FAIL both_read_pulses got %0d want 1", rd_pulses); end
      tests++; if (wr_pulses != 0) begin failed++; $display("FAIL both_write_held got %0d want 0", wr_pulses); end
      tests++; if (read_data !== 32'd12) begin failed++; $display("FAIL both_read_data got %0d want 12", read_data); end
      read_enable = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         if (write_ready === 64'd1) seen = 1;
      end
      tests++; if (!seen) begin failed++; $display("FAIL both_write_after_read got no write_ready want one pulse"); end
      write_enable = 1'b0;
      tick();
      tick();
      exp_wr++;
      tests++; if (wr_beats !== 32'(exp_wr) || busy !== 1'b0) begin failed++; $display("FAIL both_end wr_beats %0d busy %0b want %0d/0", wr_beats, busy, exp_wr); end
   endtask

   task automatic test_read_abort();
      int pulses;
      pulses = 0;
      read_addr   = 64'd0;
      read_enable = 1'b1;
      tick();
      tests++; if (busy !== 1'b1) begin failed++; $display("FAIL abort_accept busy got %0b want 1", busy); end
      read_enable = 1'b0;
      tick();
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL abort_busy got %0b want 0", busy); end
      for (int c = 0; c < 4; c++) begin
         if (read_ready === 64'd1) pulses++;
         tick();
      end
      tests++; if (pulses != 0) begin failed++; $display("FAIL abort_no_pulse got %0d want 0", pulses); end
      tests++; if (rd_beats !== 32'(exp_rd)) begin failed++; $display("FAIL abort_rd_beats got %0d want %0d", rd_beats, exp_rd); end
   endtask

   task automatic test_load_priority();
      bit seen;
      seen = 0;
      load_en     = 1'b1;
      load_addr   = 14'd7;
      load_data   = 32'h77;
      read_addr   = 64'h1C;
      read_enable = 1'b1;
      tick();
      load_en = 1'b0;
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL load_priority busy got %0b want 0", busy); end
      tick();
      for (int c = 1; c <= 20 && !seen; c++) begin
         if (read_ready === 64'd1) seen = 1;
         else tick();
      end
      tests++; if (!seen || read_data !== 32'h77) begin failed++; $display("FAIL load_then_read got %0h want 77", read_data); end
      read_enable = 1'b0;
      tick();
      tick();
      exp_rd++;
   endtask

   task automatic test_reset_mid_write();
      bit seen;
      seen = 0;
      preload(5, 32'h1234);
      write_addr   = 64'h14;
      write_data   = 32'hDEAD;
      write_enable = 1'b1;
      tick();
      tests++; if (busy !== 1'b1) begin failed++; $display("FAIL midwr_accept busy got %0b want 1", busy); end
      #1 reset = 1'b1;
      #1;
      tests++; if (busy !== 1'b0 || write_ready !== 64'd0) begin failed++; $display("FAIL midwr_async busy %0b write_ready %0d want 0/0", busy, write_ready); end
      tests++; if (rd_beats !== 32'd0 || wr_beats !== 32'd0 || read_data !== 32'd0) begin failed++; $display("FAIL midwr_clear rd %0d wr %0d data %0h want 0", rd_beats, wr_beats, read_data); end
      write_enable = 1'b0;
      tick();
      reset = 1'b0;
      exp_rd = 0;
      exp_wr = 0;
      tick();
      read_addr   = 64'h14;
      read_enable = 1'b1;
      tick();
      for (int c = 1; c <= 20 && !seen; c++) begin
         if (read_ready === 64'd1) seen = 1;
         else tick();
      end
      tests++; if (!seen || read_data !== 32'h1234) begin failed++; $display("FAIL midwr_target got %0h want 1234", read_data); end
      read_enable = 1'b0;
      tick();
      tick();
      exp_rd++;
      tests++; if (rd_beats !== 32'(exp_rd) || wr_beats !== 32'(exp_wr)) begin failed++; $display("FAIL midwr_beats rd %0d wr %0d want %0d/%0d", rd_beats, wr_beats, exp_rd, exp_wr); end
   endtask

   task automatic test_wrap();
      bit seen;
      seen = 0;
      read_addr   = 64'h10000;
      read_enable = 1'b1;
      tick();
      for (int c = 1; c <= 20 && !seen; c++) begin
         if (read_ready === 64'd1) seen = 1;
         else tick();
      end
      tests++; if (!seen || read_data !== 32'd10) begin failed++; $display("FAIL addr_wrap got %0d want 10", read_data); end
      read_enable = 1'b0;
      tick();
      tick();
      exp_rd++;
   endtask

   initial begin
      test_reset();
      test_preload_read();
      test_write_burst();
      test_both_requests();
      test_read_abort();
      test_load_priority();
      test_reset_mid_write();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
